// File: rtl/alu_issue_stage.sv
// Two-entry execute front-end for a combinational 32-bit ALU:
// decodes MIPS fields into an issue register, captures ALU results downstream.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [4:0]  in_rt_addr,
    input  logic [4:0]  in_rd_addr,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic [4:0]  out_dest,
    output logic        out_ovf_trap,
    output logic        out_illegal
);
    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] word_t;

    logic        s1_valid_q, s1_valid_d;
    word_t       s1_a_q, s1_a_d;
    word_t       s1_b_q, s1_b_d;
    logic [2:0]  s1_op_q, s1_op_d;
    logic [4:0]  s1_dest_q, s1_dest_d;
    logic        s1_signed_q, s1_signed_d;
    logic        s1_illegal_q, s1_illegal_d;

    logic        out_valid_q, out_valid_d;
    word_t       out_result_q, out_result_d;
    logic        out_zero_q, out_zero_d;
    logic [4:0]  out_dest_q, out_dest_d;
    logic        out_trap_q, out_trap_d;
    logic        out_illegal_q, out_illegal_d;

    word_t       dec_b;
    logic [2:0]  dec_op;
    logic [4:0]  dec_dest;
    logic        dec_signed;
    logic        dec_illegal;
    word_t       imm_sx;
    word_t       imm_zx;

    logic        s2_free;
    logic        s1_adv;
    logic        accept;

    always_comb begin
        imm_sx      = {{16{in_imm[15]}}, in_imm};
        imm_zx      = {16'b0, in_imm};
        dec_b       = '0;
        dec_op      = 3'b000;
        dec_dest    = '0;
        dec_signed  = 1'b0;
        dec_illegal = 1'b0;
        case (in_opcode)
            6'b000000: begin
                dec_b    = in_rt_data;
                dec_dest = in_rd_addr;
                case (in_funct)
                    6'b100000: begin dec_op = 3'b010; dec_signed = 1'b1; end
                    6'b100001: dec_op = 3'b010;
                    6'b100010: begin dec_op = 3'b110; dec_signed = 1'b1; end
                    6'b100011: dec_op = 3'b110;
                    6'b100100: dec_op = 3'b000;
                    6'b100101: dec_op = 3'b001;
                    6'b101010: dec_op = 3'b111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            6'b001000: begin
                dec_op = 3'b010; dec_b = imm_sx;
                dec_dest = in_rt_addr; dec_signed = 1'b1;
            end
            6'b001001: begin dec_op = 3'b010; dec_b = imm_sx; dec_dest = in_rt_addr; end
            6'b001010: begin dec_op = 3'b111; dec_b = imm_sx; dec_dest = in_rt_addr; end
            6'b001100: begin dec_op = 3'b000; dec_b = imm_zx; dec_dest = in_rt_addr; end
            6'b001101: begin dec_op = 3'b001; dec_b = imm_zx; dec_dest = in_rt_addr; end
            default:   dec_illegal = 1'b1;
        endcase
        // Illegal entries issue as rs AND 0 so they retire with result 0.
        if (dec_illegal) begin
            dec_op     = 3'b000;
            dec_b      = '0;
            dec_dest   = '0;
            dec_signed = 1'b0;
        end
    end

    always_comb begin
        s2_free  = ~out_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_free;
        in_ready = ~s1_valid_q | s2_free;
        accept   = in_valid & in_ready;

        s1_valid_d   = accept | (s1_valid_q & ~s1_adv);
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_dest_d    = s1_dest_q;
        s1_signed_d  = s1_signed_q;
        s1_illegal_d = s1_illegal_q;
        if (accept) begin
            s1_a_d       = in_rs_data;
            s1_b_d       = dec_b;
            s1_op_d      = dec_op;
            s1_dest_d    = dec_dest;
            s1_signed_d  = dec_signed;
            s1_illegal_d = dec_illegal;
        end

        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_dest_d    = out_dest_q;
        out_trap_d    = out_trap_q;
        out_illegal_d = out_illegal_q;
        if (s1_adv) begin
            out_valid_d   = 1'b1;
            out_result_d  = alu_result;
            out_zero_d    = alu_zero;
            out_dest_d    = s1_dest_q;
            out_trap_d    = s1_signed_q & alu_overflow;
            out_illegal_d = s1_illegal_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_op_q       <= '0;
            s1_dest_q     <= '0;
            s1_signed_q   <= 1'b0;
            s1_illegal_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_dest_q    <= '0;
            out_trap_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_op_q       <= s1_op_d;
            s1_dest_q     <= s1_dest_d;
            s1_signed_q   <= s1_signed_d;
            s1_illegal_q  <= s1_illegal_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_dest_q    <= out_dest_d;
            out_trap_q    <= out_trap_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_A        = s1_a_q;
    assign alu_B        = s1_b_q;
    assign alu_op       = s1_op_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_zero     = out_zero_q;
    assign out_dest     = out_dest_q;
    assign out_ovf_trap = out_trap_q;
    assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: drives a behavioural ALU and scores every
// retired instruction against a MIPS-level reference model.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [4:0]  in_rt_addr;
    logic [4:0]  in_rd_addr;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_dest;
    logic        out_ovf_trap;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_imm(in_imm),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_dest(out_dest), .out_ovf_trap(out_ovf_trap),
        .out_illegal(out_illegal)
    );

    // Stateless ALU as seen by the stage.
    always_comb begin
        alu_result   = 32'h0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b010: begin
                alu_result   = alu_A + alu_B;
                alu_overflow = (alu_A[31] == alu_B[31]) && (alu_result[31] != alu_A[31]);
            end
            3'b110: begin
                alu_result   = alu_A - alu_B;
                alu_overflow = (alu_A[31] != alu_B[31]) && (alu_result[31] != alu_A[31]);
            end
            3'b000:  alu_result = alu_A & alu_B;
            3'b001:  alu_result = alu_A | alu_B;
            3'b111:  alu_result = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rta;
        logic [4:0]  rda;
    } ins_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  dest;
        logic        trap;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   took;
    bit   lat_strict = 1'b0;
    bit   rand_ready = 1'b0;
    logic [31:0] last_res;
    logic        last_zero;
    logic [4:0]  last_dest;
    logic        last_trap;
    logic        last_ill;

    logic [5:0] rfn [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [5:0] iop [5] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [15:0] imm, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic [4:0] rta,
                                   input logic [4:0] rda);
        exp_t e;
        longint a, s;
        logic signed [31:0] lo;
        logic [31:0] sx, zx;
        bit sgn, ill;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        a = $signed(rs);
        s = 0;
        sgn = 0;
        ill = 0;
        e.res = 32'h0;
        e.dest = rta;
        e.acc = 0;
        if (op == 6'h00) begin
            e.dest = rda;
            case (fn)
                6'h20: begin s = a + longint'($signed(rt)); sgn = 1; e.res = s[31:0]; end
                6'h21: begin s = a + longint'($signed(rt)); e.res = s[31:0]; end
                6'h22: begin s = a - longint'($signed(rt)); sgn = 1; e.res = s[31:0]; end
                6'h23: begin s = a - longint'($signed(rt)); e.res = s[31:0]; end
                6'h24: e.res = rs & rt;
                6'h25: e.res = rs | rt;
                6'h2A: e.res = ($signed(rs) < $signed(rt)) ? 1 : 0;
                default: ill = 1;
            endcase
        end else begin
            case (op)
                6'h08: begin s = a + longint'($signed(sx)); sgn = 1; e.res = s[31:0]; end
                6'h09: begin s = a + longint'($signed(sx)); e.res = s[31:0]; end
                6'h0A: e.res = ($signed(rs) < $signed(sx)) ? 1 : 0;
                6'h0C: e.res = rs & zx;
                6'h0D: e.res = rs | zx;
                default: ill = 1;
            endcase
        end
        lo = s[31:0];
        e.trap = sgn && (longint'(lo) != s);
        if (ill) begin
            e.res = 32'h0;
            e.dest = 5'd0;
            e.trap = 1'b0;
        end
        e.ill = ill;
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom % 6)
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 3);
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        int p;
        p = int'($urandom % 16);
        i.rs = rnd_word();
        i.rt = rnd_word();
        i.imm = 16'($urandom);
        i.rta = 5'($urandom);
        i.rda = 5'($urandom);
        i.fn = 6'($urandom);
        if (p < 7) begin
            i.op = 6'h00;
            i.fn = rfn[$urandom % 7];
        end else if (p < 13) begin
            i.op = iop[$urandom % 5];
        end else if (p < 14) begin
            i.op = 6'h00;
            i.fn = 6'h27;
        end else begin
            i.op = (p == 14) ? 6'h02 : 6'h0F;
        end
        return i;
    endfunction

    function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [4:0] rta,
                                input logic [4:0] rda);
        ins_t i;
        i.op = op; i.fn = fn; i.imm = imm;
        i.rs = rs; i.rt = rt; i.rta = rta; i.rda = rda;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        in_opcode  = i.op;
        in_funct   = i.fn;
        in_imm     = i.imm;
        in_rs_data = i.rs;
        in_rt_data = i.rt;
        in_rt_addr = i.rta;
        in_rd_addr = i.rda;
        in_valid   = 1'b1;
    endtask

    // One clock: sample handshakes at the falling edge, update the model.
    task automatic step();
        exp_t e;
        if (rand_ready) out_ready = ($urandom % 3) != 0;
        @(negedge clk);
        took = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                chk("out_unexpected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("retire", {out_result, out_zero, out_dest, out_ovf_trap, out_illegal},
                        {e.res, e.zero, e.dest, e.trap, e.ill});
                    if (lat_strict) chk("latency", 64'(cyc + 1 - e.acc), 64'd2);
                end
                last_res  = out_result;
                last_zero = out_zero;
                last_dest = out_dest;
                last_trap = out_ovf_trap;
                last_ill  = out_illegal;
            end
            if (in_valid && in_ready) begin
                e = model(in_opcode, in_funct, in_imm, in_rs_data, in_rt_data,
                          in_rt_addr, in_rd_addr);
                e.acc = cyc + 1;
                q.push_back(e);
                n_acc++;
                took = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input ins_t i);
        int n;
        drive(i);
        n = 0;
        do begin
            step();
            n++;
        end while (!took && n < 50);
        in_valid = 1'b0;
        chk("send_accept", 64'(took), 64'd1);
    endtask

    task automatic drain();
        int n;
        bit keep;
        keep = rand_ready;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        rand_ready = keep;
    endtask

    initial begin
        int c0, a0;
        logic [31:0] sa, sr;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(mk(6'h00, 6'h20, 16'h0, 32'h0, 32'h0, 5'd0, 5'd0));
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_A", 64'(alu_A), 64'd0);
        chk("rst_alu_B", 64'(alu_B), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_out_fields", {out_result, out_zero, out_dest, out_ovf_trap, out_illegal}, 64'd0);

        out_ready = 1'b1;
        lat_strict = 1'b1;
        send(mk(6'h00, 6'h20, 16'h0, 32'h7FFF_FFFF, 32'h1, 5'd3, 5'd7));
        drain();
        chk("add_res", 64'(last_res), 64'h8000_0000);
        chk("add_trap", 64'(last_trap), 64'd1);
        send(mk(6'h00, 6'h21, 16'h0, 32'h7FFF_FFFF, 32'h1, 5'd3, 5'd7));
        drain();
        chk("addu_res", 64'(last_res), 64'h8000_0000);
        chk("addu_trap", 64'(last_trap), 64'd0);

        send(mk(6'h0C, 6'h00, 16'hFFFF, 32'h1234_5678, 32'h0, 5'd9, 5'd2));
        drain();
        chk("andi", {last_res, last_dest}, {32'h0000_5678, 5'd9});
        send(mk(6'h09, 6'h00, 16'hFFFF, 32'd5, 32'h0, 5'd10, 5'd2));
        drain();
        chk("addiu", {last_res, last_dest}, {32'd4, 5'd10});
        send(mk(6'h0A, 6'h00, 16'h8000, 32'd0, 32'h0, 5'd11, 5'd2));
        drain();
        chk("slti", {last_res, last_dest}, {32'd0, 5'd11});

        c0 = cyc;
        repeat (8) send(rand_ins());
        chk("tput_cycles", 64'(cyc - c0), 64'd8);
        drain();

        lat_strict = 1'b0;
        out_ready = 1'b0;
        a0 = n_acc;
        send(rand_ins());
        send(rand_ins());
        drive(rand_ins());
        sa = alu_A;
        sr = out_result;
        repeat (3) step();
        chk("bp_accepted", 64'(n_acc - a0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_alu", 64'(alu_A), 64'(sa));
        chk("bp_hold_out", {31'h0, out_valid, out_result}, {31'h0, 1'b1, sr});
        out_ready = 1'b1;
        c0 = 0;
        do begin
            step();
            c0++;
        end while (!took && c0 < 20);
        in_valid = 1'b0;
        chk("bp_third", 64'(took), 64'd1);
        drain();

        lat_strict = 1'b1;
        send(mk(6'h02, 6'h00, 16'h1234, 32'hDEAD_BEEF, 32'h1, 5'd4, 5'd5));
        drain();
        chk("illegal", {last_ill, last_res, last_zero, last_dest},
            {1'b1, 32'h0, 1'b1, 5'd0});
        send(mk(6'h00, 6'h22, 16'h0, 32'h8000_0000, 32'h8000_0000, 5'd1, 5'd6));
        drain();
        chk("sub_eq", {last_res, last_zero, last_trap}, {32'h0, 1'b1, 1'b0});
        send(mk(6'h00, 6'h2A, 16'h0, 32'hFFFF_FFFF, 32'h1, 5'd1, 5'd8));
        drain();
        chk("slt_neg", 64'(last_res), 64'd1);

        lat_strict = 1'b0;
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom % 4 == 0) step();
            send(rand_ins());
        end
        drain();
        rand_ready = 1'b0;

        out_ready = 1'b0;
        send(rand_ins());
        send(rand_ins());
        chk("mid_full", {62'h0, out_valid, in_ready}, {62'h0, 1'b1, 1'b0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_cleared", {out_result, alu_A, 3'b0, alu_op}, 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_no_stale", 64'(out_valid), 64'd0);
        end
        chk("final_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
